// File: rtl/uart_pkt_pkg.sv
// Shared types and constants for the UART packet parser.
package uart_pkt_pkg;

  typedef enum logic [1:0] {
    HUNT,
    LEN,
    PAYLOAD,
    CSUM
  } state_t;

  localparam logic [1:0] ST_OK       = 2'd0;
  localparam logic [1:0] ST_CSUM_ERR = 2'd1;
  localparam logic [1:0] ST_LEN_ERR  = 2'd2;
  localparam logic [1:0] ST_LINE_ERR = 2'd3;

  localparam logic [7:0] SOF_BYTE_DEFAULT = 8'hA5;

  // Saturating 16-bit increment for the statistics counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/uart_pkt_timeout.sv
// Inter-byte idle counter: clearable, loadable, flags expiry at TIMEOUT_CYC.
module uart_pkt_timeout #(
  parameter int unsigned TIMEOUT_CYC = 100000,
  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          inc,
  output logic          expired
);

  logic [CW-1:0] cnt;

  assign expired = (cnt >= CW'(TIMEOUT_CYC));

  // Count idle cycles, holding at the expiry value until cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (inc && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_pkt_parser.sv
// Framed packet parser (SOF, LEN, PAYLOAD[LEN], CSUM) on the RX FIFO read port.
// Optional statistics counters: define UART_PKT_ERR_CNT_EN.
module uart_pkt_parser
  import uart_pkt_pkg::*;
#(
  parameter int unsigned       N_BIT       = 8,
  parameter logic [N_BIT-1:0]  SOF_BYTE    = N_BIT'(SOF_BYTE_DEFAULT),
  parameter int unsigned       MAX_LEN     = 64,
  parameter int unsigned       TIMEOUT_CYC = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_empty,
  output logic             rx_rd_en,
  input  logic [N_BIT-1:0] rx_rd_data,
  input  logic             rx_parity_error,
  input  logic             rx_frame_error,
  output logic [N_BIT-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic             pkt_done,
  output logic [1:0]       pkt_status
`ifdef UART_PKT_ERR_CNT_EN
  ,
  output logic [15:0]      ok_cnt,
  output logic [15:0]      csum_err_cnt,
  output logic [15:0]      len_err_cnt,
  output logic [15:0]      line_err_cnt
`endif
);

  localparam int unsigned TCW = $clog2(TIMEOUT_CYC + 1);

  state_t           state, state_nxt;
  logic             in_flight;
  logic [N_BIT-1:0] csum, csum_nxt;
  logic [N_BIT-1:0] remain, remain_nxt;
  logic             capture, line_err, can_absorb;
  logic             tmo_clr, tmo_inc, tmo_expired;
  logic             load_out, load_last, done_nxt;
  logic [1:0]       status_nxt;

  assign capture    = in_flight;
  assign line_err   = rx_parity_error | rx_frame_error;
  // The output register is free by the capture cycle if it is free (or draining) now.
  assign can_absorb = (state != PAYLOAD) || !out_valid || out_ready;
  assign rx_rd_en   = !rst && !rx_empty && !in_flight && can_absorb;

  assign tmo_clr = capture || (state == HUNT);
  assign tmo_inc = (state != HUNT) && rx_empty && !in_flight;

  uart_pkt_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmo_clr),
    .load     (1'b0),
    .load_val ({TCW{1'b0}}),
    .inc      (tmo_inc),
    .expired  (tmo_expired)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HUNT;
    else     state <= state_nxt;
  end

  // Next-state and per-byte datapath decisions; a capture outranks timeout expiry.
  always_comb begin
    state_nxt  = state;
    csum_nxt   = csum;
    remain_nxt = remain;
    load_out   = 1'b0;
    load_last  = 1'b0;
    done_nxt   = 1'b0;
    status_nxt = ST_OK;
    if ((state != HUNT) && ((capture && line_err) || (!capture && tmo_expired))) begin
      done_nxt   = 1'b1;
      status_nxt = ST_LINE_ERR;
      state_nxt  = HUNT;
    end else if (capture) begin
      case (state)
        HUNT: begin
          if (!line_err && (rx_rd_data == SOF_BYTE)) begin
            state_nxt = LEN;
            csum_nxt  = '0;
          end
        end
        LEN: begin
          if ((rx_rd_data == '0) || (rx_rd_data > N_BIT'(MAX_LEN))) begin
            done_nxt   = 1'b1;
            status_nxt = ST_LEN_ERR;
            state_nxt  = HUNT;
          end else begin
            remain_nxt = rx_rd_data;
            csum_nxt   = rx_rd_data;
            state_nxt  = PAYLOAD;
          end
        end
        PAYLOAD: begin
          load_out   = 1'b1;
          load_last  = (remain == N_BIT'(1));
          csum_nxt   = csum ^ rx_rd_data;
          remain_nxt = remain - N_BIT'(1);
          if (remain == N_BIT'(1)) state_nxt = CSUM;
        end
        CSUM: begin
          done_nxt   = 1'b1;
          status_nxt = (rx_rd_data == csum) ? ST_OK : ST_CSUM_ERR;
          state_nxt  = HUNT;
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  // Read tracking, checksum/count, status pulse and output holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_flight  <= 1'b0;
      csum       <= '0;
      remain     <= '0;
      pkt_done   <= 1'b0;
      pkt_status <= ST_OK;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
    end else begin
      in_flight  <= rx_rd_en;
      csum       <= csum_nxt;
      remain     <= remain_nxt;
      pkt_done   <= done_nxt;
      pkt_status <= done_nxt ? status_nxt : ST_OK;
      if (load_out) begin
        out_data  <= rx_rd_data;
        out_valid <= 1'b1;
        out_last  <= load_last;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

`ifdef UART_PKT_ERR_CNT_EN
  // Per-status packet counters, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ok_cnt       <= '0;
      csum_err_cnt <= '0;
      len_err_cnt  <= '0;
      line_err_cnt <= '0;
    end else if (pkt_done) begin
      case (pkt_status)
        ST_OK:       ok_cnt       <= sat_inc16(ok_cnt);
        ST_CSUM_ERR: csum_err_cnt <= sat_inc16(csum_err_cnt);
        ST_LEN_ERR:  len_err_cnt  <= sat_inc16(len_err_cnt);
        default:     line_err_cnt <= sat_inc16(line_err_cnt);
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_uart_pkt_parser.sv
// Self-checking bench for uart_pkt_parser: FIFO model, output/status scoreboards.
module tb_uart_pkt_parser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_empty = 1'b1;
  logic [7:0] rx_rd_data = '0;
  logic       rx_parity_error = 1'b0;
  logic       rx_frame_error = 1'b0;
  logic       out_ready = 1'b1;
  logic       rx_rd_en;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       pkt_done;
  logic [1:0] pkt_status;
`ifdef UART_PKT_ERR_CNT_EN
  logic [15:0] ok_cnt, csum_err_cnt, len_err_cnt, line_err_cnt;
`endif

  logic [9:0] fifo_q[$];
  logic [8:0] exp_byte_q[$];
  logic [1:0] exp_stat_q[$];
  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  uart_pkt_parser #(
    .N_BIT(8),
    .SOF_BYTE(8'hA5),
    .MAX_LEN(64),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_empty(rx_empty),
    .rx_rd_en(rx_rd_en),
    .rx_rd_data(rx_rd_data),
    .rx_parity_error(rx_parity_error),
    .rx_frame_error(rx_frame_error),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_last(out_last),
    .out_ready(out_ready),
    .pkt_done(pkt_done),
    .pkt_status(pkt_status)
`ifdef UART_PKT_ERR_CNT_EN
    ,
    .ok_cnt(ok_cnt),
    .csum_err_cnt(csum_err_cnt),
    .len_err_cnt(len_err_cnt),
    .line_err_cnt(line_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // RX FIFO model: pop on rx_rd_en, data and error flags valid the next cycle.
  always @(posedge clk) begin
    logic [9:0] e;
    if (rx_rd_en) begin
      chk("pop_nonempty", 16'(fifo_q.size() != 0), 16'd1);
      if (fifo_q.size() != 0) begin
        e = fifo_q.pop_front();
        rx_rd_data      <= e[7:0];
        rx_parity_error <= e[8];
        rx_frame_error  <= e[9];
      end
    end
    rx_empty <= (fifo_q.size() == 0);
  end

  // Output and status monitors, sampled mid-cycle.
  always @(negedge clk) begin
    logic [15:0] e;
    if (out_valid && out_ready) begin
      e = (exp_byte_q.size() != 0) ? 16'(exp_byte_q.pop_front()) : 16'hFFFF;
      chk("out_byte", {7'd0, out_last, out_data}, e);
    end
    if (pkt_done) begin
      e = (exp_stat_q.size() != 0) ? 16'(exp_stat_q.pop_front()) : 16'hFFFF;
      chk("pkt_status", 16'(pkt_status), e);
      done_cnt++;
    end
  end

  task automatic push(input logic [7:0] b, input logic perr = 1'b0, input logic ferr = 1'b0);
    fifo_q.push_back({ferr, perr, b});
  endtask

  task automatic exp_byte(input logic [7:0] b, input logic last);
    exp_byte_q.push_back({last, b});
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 3000; i++) begin
      if (done_cnt >= target) break;
      @(negedge clk);
    end
    chk("done_reached", 16'(done_cnt >= target), 16'd1);
  endtask

  task automatic wait_out_valid();
    for (int i = 0; i < 200; i++) begin
      if (out_valid) break;
      @(negedge clk);
    end
    chk("out_valid_seen", 16'(out_valid), 16'd1);
  endtask

  // Clean frame of n bytes starting at value first, incrementing.
  task automatic send_good(input int unsigned n, input logic [7:0] first);
    logic [7:0] c, b;
    c = 8'(n);
    push(8'hA5);
    push(8'(n));
    for (int unsigned i = 0; i < n; i++) begin
      b = first + 8'(i);
      c = c ^ b;
      push(b);
      exp_byte(b, i == n - 1);
    end
    push(c);
    exp_stat_q.push_back(2'd0);
  endtask

  initial begin
    // Reset: outputs idle, no pop even with data waiting.
    repeat (2) @(negedge clk);
    push(8'h00);
    repeat (3) @(negedge clk);
    chk("rst_rd_en", 16'(rx_rd_en), 16'd0);
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_out_last", 16'(out_last), 16'd0);
    chk("rst_out_data", 16'(out_data), 16'd0);
    chk("rst_pkt_done", 16'(pkt_done), 16'd0);
    chk("rst_pkt_status", 16'(pkt_status), 16'd0);
    rst = 1'b0;

    // Good frame
    push(8'hA5); push(8'h03); push(8'h11); push(8'h22); push(8'h33); push(8'h03);
    exp_byte(8'h11, 0); exp_byte(8'h22, 0); exp_byte(8'h33, 1);
    exp_stat_q.push_back(2'd0);
    wait_done(1);

    // Garbage ahead of a one-byte frame
    push(8'h00); push(8'hFF); push(8'hA5); push(8'h01); push(8'h7E); push(8'h7F);
    exp_byte(8'h7E, 1);
    exp_stat_q.push_back(2'd0);
    wait_done(2);

    // Bad checksum
    push(8'hA5); push(8'h02); push(8'h10); push(8'h20); push(8'h00);
    exp_byte(8'h10, 0); exp_byte(8'h20, 1);
    exp_stat_q.push_back(2'd1);
    wait_done(3);

    // Length errors: zero and MAX_LEN+1
    push(8'hA5); push(8'h00);
    exp_stat_q.push_back(2'd2);
    push(8'hA5); push(8'h41);
    exp_stat_q.push_back(2'd2);
    wait_done(5);

    // Maximum length, payload includes the SOF value as data
    send_good(64, 8'h80);
    wait_done(6);

    // Backpressure mid-payload: no abort, nothing lost
    out_ready = 1'b0;
    push(8'hA5); push(8'h04); push(8'h01); push(8'h02); push(8'h03); push(8'h04); push(8'h00);
    exp_byte(8'h01, 0); exp_byte(8'h02, 0); exp_byte(8'h03, 0); exp_byte(8'h04, 1);
    exp_stat_q.push_back(2'd0);
    wait_out_valid();
    chk("stall_data", 16'(out_data), 16'h01);
    repeat (50) @(negedge clk);
    chk("stall_no_abort", 16'(done_cnt), 16'd6);
    chk("stall_hold_valid", 16'(out_valid), 16'd1);
    chk("stall_hold_data", 16'(out_data), 16'h01);
    out_ready = 1'b1;
    wait_done(7);

    // Inter-byte timeout
    push(8'hA5); push(8'h02); push(8'hAA);
    exp_byte(8'hAA, 0);
    exp_stat_q.push_back(2'd3);
    wait_done(8);

    // Parity error on second payload byte, then a clean frame
    push(8'hA5); push(8'h03); push(8'h01); push(8'h02, 1'b1); push(8'h03); push(8'h01);
    exp_byte(8'h01, 0);
    exp_stat_q.push_back(2'd3);
    push(8'hA5); push(8'h01); push(8'h55); push(8'h54);
    exp_byte(8'h55, 1);
    exp_stat_q.push_back(2'd0);
    wait_done(10);

    // Framing error on the checksum byte
    push(8'hA5); push(8'h01); push(8'h33); push(8'h32, 1'b0, 1'b1);
    exp_byte(8'h33, 1);
    exp_stat_q.push_back(2'd3);
    wait_done(11);

`ifdef UART_PKT_ERR_CNT_EN
    @(negedge clk);
    chk("ok_cnt", ok_cnt, 16'd5);
    chk("csum_err_cnt", csum_err_cnt, 16'd1);
    chk("len_err_cnt", len_err_cnt, 16'd2);
    chk("line_err_cnt", line_err_cnt, 16'd3);
`endif

    // Reset mid-frame: outputs clear, no status pulse
    out_ready = 1'b0;
    push(8'hA5); push(8'h03); push(8'h11);
    wait_out_valid();
    chk("mid_data", 16'(out_data), 16'h11);
    chk("mid_last", 16'(out_last), 16'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 16'(out_valid), 16'd0);
    chk("mid_rst_done", 16'(pkt_done), 16'd0);
    chk("mid_rst_rd_en", 16'(rx_rd_en), 16'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (40) @(negedge clk);
    chk("mid_rst_no_done", 16'(done_cnt), 16'd11);
    chk("mid_rst_idle", 16'(out_valid), 16'd0);

    repeat (5) @(negedge clk);
    chk("byte_q_empty", 16'(exp_byte_q.size()), 16'd0);
    chk("stat_q_empty", 16'(exp_stat_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_pkt_parser.md
Name: uart_pkt_parser

Overview:
- Consumes bytes from the UART receiver's RX FIFO read port and parses framed packets of the form SOF, LEN, PAYLOAD[LEN], CSUM.
- Streams validated-length payload bytes downstream on a valid/ready interface.
- Reports per-packet status on a one-cycle done pulse.
- Sits directly downstream of the receiver FIFO in the UART subsystem.

Parameters:
- N_BIT, 8: byte width; must match the UART data width.
- SOF_BYTE, 8'hA5: start-of-frame marker.
- MAX_LEN, 64: maximum legal payload length (1..255).
- TIMEOUT_CYC, 100000: idle clk cycles allowed between bytes inside a frame before abort.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- rx_empty  in  1  RX FIFO empty
- rx_rd_en  out  1  RX FIFO pop request, one-cycle pulse
- rx_rd_data  in  N_BIT  FIFO read data; valid the cycle after rx_rd_en
- rx_parity_error  in  1  receiver parity error, sampled with rx_rd_data
- rx_frame_error  in  1  receiver framing error, sampled with rx_rd_data
- out_data  out  N_BIT  payload byte
- out_valid  out  1  out_data valid
- out_last  out  1  final payload byte of the frame
- out_ready  in  1  downstream accept
- pkt_done  out  1  one-cycle pulse when a frame completes or aborts
- pkt_status  out  2  0=OK, 1=CSUM_ERR, 2=LEN_ERR, 3=LINE_ERR/TIMEOUT; valid with pkt_done

Behaviour:
- Interface:
  - One clock domain.
  - Reset is asynchronous, active-high, on rst. The clock port is clk.
- Reset values:
  - All outputs are 0.
  - FSM is in HUNT.
  - Checksum and timeout counters are 0.
- Read handshake:
  - rx_rd_en asserts only when rx_empty=0, no read is in flight, and the FSM can absorb a byte.
  - In PAYLOAD, "can absorb" additionally requires the output register to be empty or (out_valid and out_ready) this cycle.
  - The byte is captured one cycle after rx_rd_en. Maximum rate is one byte per 2 cycles.
- FSM:
  - HUNT: pop and discard bytes until one equals SOF_BYTE; then go to LEN and clear the checksum.
  - LEN: capture the byte.
    - If it is 0 or > MAX_LEN: pulse pkt_done with status 2, go to HUNT.
    - Otherwise: load the remaining count, set csum = byte, go to PAYLOAD.
  - PAYLOAD: each byte is loaded into out_data with out_valid=1; csum ^= byte.
    - out_last=1 on the byte where the count reaches 0.
    - After the last byte, go to CSUM.
  - CSUM: compare the byte with csum. Pulse pkt_done with status 0 on match, 1 on mismatch. Go to HUNT.
- Output register:
  - out_data, out_valid and out_last hold until out_ready.
  - out_valid deasserts after acceptance unless a new byte loads in the same cycle.
- Line errors:
  - If rx_parity_error or rx_frame_error is high when a byte is captured in LEN, PAYLOAD or CSUM: abort, pulse pkt_done with status 3, go to HUNT.
  - In HUNT, such bytes are simply discarded.
- Timeout:
  - The counter increments in LEN, PAYLOAD and CSUM while rx_empty=1 and no read is in flight.
  - It clears on every byte capture and on entry to HUNT.
  - Stalls caused by out_ready=0 do not count.
  - Reaching TIMEOUT_CYC: pulse pkt_done with status 3, go to HUNT.
- Aborts:
  - An abort mid-PAYLOAD emits no out_last. Bytes already streamed remain.
  - The consumer discards the partial packet on a nonzero pkt_status.
  - An already-loaded output byte still completes its handshake.
- Simultaneous events: a byte capture in the same cycle as timeout expiry takes priority (byte processed, timer cleared).
- SOF_BYTE inside LEN, PAYLOAD or CSUM is treated as data; there is no resync.
- Reset mid-frame: immediate return to HUNT with outputs cleared. No pkt_done is emitted.

Optional Feature:
- Macro: UART_PKT_ERR_CNT_EN.
- When defined:
  - Adds output ports ok_cnt[15:0], csum_err_cnt[15:0], len_err_cnt[15:0], line_err_cnt[15:0].
  - Each counter increments on a pkt_done with the matching status and saturates at 16'hFFFF.
  - Counters reset to 0 on rst.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package uart_pkt_pkg holds:
  - the FSM state enum (HUNT, LEN, PAYLOAD, CSUM);
  - status codes ST_OK, ST_CSUM_ERR, ST_LEN_ERR, ST_LINE_ERR;
  - the default SOF_BYTE.
- One sub-module, uart_pkt_timeout: a loadable/clearable cycle counter with an expiry flag, parameterised by TIMEOUT_CYC.

Test Plan:
- Good frame: FIFO holds A5 03 11 22 33 11^22^33^03=03 → out_data 11, 22, 33 with out_last on 33; pkt_done with status 0.
- Garbage then frame: 00 FF A5 01 7E 7F (csum 01^7E) → 00 and FF discarded; single byte 7E out with out_last; status 0.
- Bad checksum: A5 02 10 20 00 → bytes 10 and 20 out; status 1.
- Length error: A5 00, then A5 41 with MAX_LEN=64 → status 2 each time; no output bytes.
- Backpressure plus timeout: out_ready=0 for 50 cycles mid-payload → no abort and bytes are not lost. Separately, FIFO empty after A5 02 AA for TIMEOUT_CYC=16 cycles → status 3.
- Line error: rx_parity_error=1 with the second payload byte → status 3; the next clean frame parses OK.
